day_scan_controller: RTL
========================

// Module: day_scan_controller
// PURPOSE
//  Sequencer for the day-of-week 7-segment display. Holds the current day (MON..SUN),
//  advances it on a programmable frame count or on a manual step, and time-multiplexes
//  DIGITS letter positions onto one shared segment bus with a blanking guard slot.
//  Sits between the board clock and the 7-segment pins; letter patterns come from day_letter_rom.
// PARAMETERS
//  DIGITS    4     letter positions scanned, 1..8
//  SCAN_DIV  1000  clk cycles each digit is driven (DRIVE length), >=1
//  DAY_DIV   250   full scan frames per automatic day advance, >=1
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  run        in   1       1 = scan and auto-advance; sampled at slot boundaries only
//  step       in   1       one-cycle pulse: advance day by one immediately
//  seg        out  7       {A,B,C,D,E,F,G}, active-high, registered
//  an         out  DIGITS  digit enables, active-low, registered; at most one bit low
//  day        out  3       current day, MON=0 .. SUN=6; 7 never produced
//  day_tick   out  1       one-cycle pulse on any day change
// BEHAVIOUR
//  Reset: state=IDLE, day=MON, digit=0, slot_cnt=0, frame_cnt=0, seg=7'b0, an=all 1s, day_tick=0.
//  FSM states:
//   IDLE:  seg=0, an=all 1s. run=1 -> BLANK next cycle.
//   BLANK: exactly 1 cycle, seg=0, an=all 1s (anti-ghosting guard). Always -> DRIVE.
//          Upon entering DRIVE, seg is loaded with LETTER_TBL[day][digit], and an[digit] is driven to 0.
//   DRIVE: lasts SCAN_DIV cycles, during which seg/an are held. On the last cycle:
//          digit <= (digit==DIGITS-1) ? 0 : digit+1;
//          on wrap, frame_cnt increments; if frame_cnt==DAY_DIV-1 at wrap, frame_cnt<=0 and the day auto-advances;
//          then go to BLANK if run=1, else to IDLE (day/digit/frame_cnt retained).
//  Slot = SCAN_DIV+1 cycles; frame = DIGITS*(SCAN_DIV+1); auto day period = DAY_DIV frames.
//  Day advance: SUN(6) -> MON(0) wrap. day_tick is asserted the same cycle day takes its new value.
//  step: works in every state. day advances by one on the next edge, and frame_cnt clears to 0.
//   If step coincides with an auto-advance, the day advances by ONE only (no double step).
//   A step does not reload seg mid-DRIVE; the new day is shown from the next slot.
//  run deasserted mid-DRIVE: the current slot completes and is then blanked (IDLE). No partial slot.
//  rst has priority over step/run at the same edge; rst mid-DRIVE blanks outputs the next cycle.
//  Counters: slot_cnt is $clog2(SCAN_DIV+1) bits, frame_cnt is $clog2(DAY_DIV+1) bits, digit is $clog2(DIGITS) bits (min 1).
//   All counters are unsigned and never exceed their terminal value.
// STRUCTURE
//  Shared package day_pkg:
//   - day encodings MON..SUN (3-bit)
//   - SEG_BLANK = 7'b0
//   - LETTER_TBL[7][8] of 7-bit patterns
//   - FSM state encoding IDLE/BLANK/DRIVE.
//  Sub-module day_letter_rom (combinational; day, idx -> seg pattern from LETTER_TBL);
//   instantiated once here, with its output registered in this block.
//  Everything else is here: FSM, slot/frame/digit counters, day register.
// TESTING  (SCAN_DIV=3, DAY_DIV=2, DIGITS=4 unless noted)
//  1 rst held 3 cycles, then released with run=0 -> seg=0, an=4'b1111, day=0, and day_tick never pulses for 50 cycles.
//  2 run=1 from reset -> IDLE 1 cycle, BLANK 1, then an=1110 for 3 cycles, blank 1, an=1101 for 3, ...;
//    seg is checked each slot against LETTER_TBL[0][digit].
//  3 run=1 continuously -> day_tick every 32 cycles;
//    day goes 0,1,..,6,0, with the wrap SUN->MON checked at the 7th tick.
//  4 step pulse while IDLE -> day 0->1 next cycle, day_tick=1 for 1 cycle;
//    step coincident with the auto-advance edge -> day +1 only, and the next auto tick lands 32 cycles later.
//  5 run dropped at cycle 1 of DRIVE on digit 2 -> an=1011 held to the slot end, then an=1111/seg=0;
//    run re-raised -> BLANK then digit 3 is driven.
//  6 rst asserted mid-DRIVE with day=5 -> next cycle an=1111, seg=0, day=0, state IDLE;
//    DIGITS=1 build scans an=0 with a blank slot between every drive.

Source files
------------

// File: rtl/day_pkg.sv
// Shared encodings for the day-of-week scan display: day codes, FSM states
// and the letter pattern table (segments ordered {A,B,C,D,E,F,G}, active-high).
package day_pkg;

    typedef enum logic [2:0] {
        MON = 3'd0,
        TUE = 3'd1,
        WED = 3'd2,
        THU = 3'd3,
        FRI = 3'd4,
        SAT = 3'd5,
        SUN = 3'd6
    } day_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Approximated glyphs; lowercase forms where uppercase is unreadable on 7 segments
    localparam logic [6:0] L_A = 7'b1110111;
    localparam logic [6:0] L_D = 7'b0111101;
    localparam logic [6:0] L_E = 7'b1001111;
    localparam logic [6:0] L_F = 7'b1000111;
    localparam logic [6:0] L_H = 7'b0110111;
    localparam logic [6:0] L_I = 7'b0000110;
    localparam logic [6:0] L_M = 7'b1110110;
    localparam logic [6:0] L_N = 7'b0010101;
    localparam logic [6:0] L_O = 7'b1111110;
    localparam logic [6:0] L_R = 7'b0000101;
    localparam logic [6:0] L_S = 7'b1011011;
    localparam logic [6:0] L_T = 7'b0001111;
    localparam logic [6:0] L_U = 7'b0111110;
    localparam logic [6:0] L_W = 7'b0011100;

    localparam logic [6:0] LETTER_TBL [7][8] = '{
        '{L_M, L_O, L_N, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{L_T, L_U, L_E, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{L_W, L_E, L_D, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{L_T, L_H, L_U, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{L_F, L_R, L_I, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{L_S, L_A, L_T, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK},
        '{L_S, L_U, L_N, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK}
    };

    function automatic day_e day_next(input day_e d);
        return (d == SUN) ? MON : day_e'(d + 3'd1);
    endfunction

endpackage

// File: rtl/day_letter_rom.sv
// Combinational lookup of the segment pattern for one letter position of a day.
module day_letter_rom
    import day_pkg::*;
(
    input  logic [2:0] day_i,
    input  logic [2:0] idx_i,
    output logic [6:0] seg_o
);

    // Code 7 is never produced by the day register; guard it anyway
    always_comb begin
        seg_o = SEG_BLANK;
        if (day_i <= 3'd6) seg_o = LETTER_TBL[day_i][idx_i];
    end

endmodule

// File: rtl/day_scan_controller.sv
// Day-of-week display sequencer: holds the day, advances it by frame count or
// step, and scans DIGITS letters onto a shared segment bus with a blank guard slot.
module day_scan_controller
    import day_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DAY_DIV  = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic [2:0]        day,
    output logic              day_tick
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int FW = $clog2(DAY_DIV + 1);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(DAY_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [FW-1:0]     frame_q, frame_d;
    day_e              day_q, day_d;
    logic              tick_q, tick_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [6:0] rom_seg;
    logic       slot_last;
    logic       digit_wrap;
    logic       auto_adv;

    day_letter_rom u_rom (
        .day_i (day_q),
        .idx_i (3'(digit_q)),
        .seg_o (rom_seg)
    );

    assign slot_last  = (state_q == ST_DRIVE) && (slot_q == SLOT_LAST);
    assign digit_wrap = slot_last && (digit_q == DIG_LAST);
    assign auto_adv   = digit_wrap && (frame_q == FRAME_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; run is only looked at on slot boundaries
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_BLANK;
            ST_BLANK: state_d = ST_DRIVE;
            ST_DRIVE: if (slot_last) state_d = run ? ST_BLANK : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: load the letter when a drive slot starts, hold it through the slot
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (state_d == ST_DRIVE) begin
            if (state_q == ST_DRIVE) begin
                seg_d = seg_q;
                an_d  = an_q;
            end else begin
                seg_d = rom_seg;
                an_d  = ~(DIGITS'(1) << digit_q);
            end
        end
    end

    // Counters and day; a step clears the frame count and absorbs a coincident auto advance
    always_comb begin
        slot_d  = '0;
        digit_d = digit_q;
        frame_d = frame_q;
        if (state_q == ST_DRIVE && !slot_last) slot_d = slot_q + 1'b1;
        if (slot_last) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        if (digit_wrap) frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
        if (step) frame_d = '0;
        tick_d = step | auto_adv;
        day_d  = tick_d ? day_next(day_q) : day_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            digit_q <= '0;
            frame_q <= '0;
            day_q   <= MON;
            tick_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            slot_q  <= slot_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            day_q   <= day_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign day      = day_q;
    assign day_tick = tick_q;

endmodule
